// File: rtl/pwm_duty_sequencer_pkg.sv
// rtl/pwm_duty_sequencer_pkg.sv - shared state type, duty width and duty defaults for the duty sequencer
package pwm_duty_sequencer_pkg;

  localparam int DUTY_W        = 4;
  localparam int DEF_MIN_DUTY  = 1;
  localparam int DEF_MAX_DUTY  = 9;
  localparam int DEF_INIT_DUTY = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_PRESS,
    S_RELEASE
  } seq_state_e;

  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] v,
    input logic [DUTY_W-1:0] lo,
    input logic [DUTY_W-1:0] hi
  );
    logic [DUTY_W-1:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/pwm_duty_sequencer_seq_timer.sv
// rtl/pwm_duty_sequencer_seq_timer.sv - loadable down-counter timing button hold and release phases
module seq_timer #(
  parameter int TIMER_W = 28
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) count_d = load_val_i;
    else if (count_q != '0) count_d = count_q - TIMER_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - steps the PWM generator duty one button press at a time toward a commanded target
module pwm_duty_sequencer
  import pwm_duty_sequencer_pkg::*;
#(
  parameter int MIN_DUTY       = DEF_MIN_DUTY,
  parameter int MAX_DUTY       = DEF_MAX_DUTY,
  parameter int INIT_DUTY      = DEF_INIT_DUTY,
  parameter int HOLD_CYCLES    = 50_000_010,
  parameter int RELEASE_CYCLES = 50_000_010,
  parameter int TIMER_W        = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_home,
  input  logic [DUTY_W-1:0] cmd_target,
  output logic              increase_duty,
  output logic              decrease_duty,
  output logic [DUTY_W-1:0] duty_shadow,
  output logic              busy,
  output logic              done
);

  localparam logic [DUTY_W-1:0]  MIN_D        = DUTY_W'(MIN_DUTY);
  localparam logic [DUTY_W-1:0]  MAX_D        = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0]  INIT_D       = DUTY_W'(INIT_DUTY);
  localparam logic [DUTY_W-1:0]  HOME_PRESSES = DUTY_W'(MAX_DUTY - MIN_DUTY);
  localparam logic [TIMER_W-1:0] HOLD_LOAD    = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REL_LOAD     = TIMER_W'(RELEASE_CYCLES - 1);

  seq_state_e        state_q;
  logic [DUTY_W-1:0] target_q, press_cnt_q, shadow_q;
  logic              home_q, inc_q, dec_q, ready_q, busy_q, done_q;

  logic [DUTY_W-1:0]  tgt_c;
  logic               finish_now, accept_done, timer_zero, timer_load;
  logic [TIMER_W-1:0] timer_val;

  assign tgt_c       = clamp_duty(cmd_target, MIN_D, MAX_D);
  assign finish_now  = home_q ? (press_cnt_q == '0) : (shadow_q == target_q);
  assign accept_done = cmd_home ? (HOME_PRESSES == '0) : (shadow_q == tgt_c);

  // The timer reloads on entry to PRESS (hold length) and to RELEASE (release length).
  always_comb begin
    timer_load = 1'b0;
    timer_val  = HOLD_LOAD;
    if (state_q == S_EVAL && !finish_now) begin
      timer_load = 1'b1;
      timer_val  = HOLD_LOAD;
    end else if (state_q == S_PRESS && timer_zero) begin
      timer_load = 1'b1;
      timer_val  = REL_LOAD;
    end
  end

  seq_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .zero_o    (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      press_cnt_q <= '0;
      shadow_q    <= INIT_D;
      home_q      <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            target_q <= tgt_c;
            home_q   <= cmd_home;
            if (cmd_home) press_cnt_q <= HOME_PRESSES;
            done_q   <= accept_done;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (finish_now) begin
            if (home_q) shadow_q <= MIN_D;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (home_q) press_cnt_q <= press_cnt_q - DUTY_W'(1);
            inc_q   <= !home_q && (shadow_q < target_q);
            dec_q   <= home_q || (shadow_q > target_q);
            state_q <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (timer_zero) begin
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            state_q <= S_RELEASE;
            // Home presses blindly, so the shadow must not wrap below the generator's clamp.
            if (inc_q) shadow_q <= shadow_q + DUTY_W'(1);
            else if (home_q && shadow_q <= MIN_D) shadow_q <= MIN_D;
            else shadow_q <= shadow_q - DUTY_W'(1);
          end
        end
        S_RELEASE: begin
          if (timer_zero) begin
            done_q  <= finish_now;
            state_q <= S_EVAL;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign increase_duty = inc_q;
  assign decrease_duty = dec_q;
  assign duty_shadow   = shadow_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb/tb_pwm_duty_sequencer.sv - randomized self-checking bench against a cycle-timeline duty model
module tb_pwm_duty_sequencer;

  localparam int HOLD = 4;
  localparam int REL  = 3;
  localparam int P    = 1 + HOLD + REL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_home = 1'b0;
  logic [3:0] cmd_target = 4'd0;
  logic       cmd_ready, increase_duty, decrease_duty, busy, done;
  logic [3:0] duty_shadow;

  int n_checks = 0;
  int n_errors = 0;
  int model_shadow = 5;

  always #5 clk = ~clk;

  pwm_duty_sequencer #(
    .HOLD_CYCLES   (HOLD),
    .RELEASE_CYCLES(REL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_home     (cmd_home),
    .cmd_target   (cmd_target),
    .increase_duty(increase_duty),
    .decrease_duty(decrease_duty),
    .duty_shadow  (duty_shadow),
    .busy         (busy),
    .done         (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ph, input int e_inc, input int e_dec, input int e_sh,
                               input int e_done, input int e_ready, input int e_busy);
    check_eq({ph, ".inc"},   32'(increase_duty), e_inc);
    check_eq({ph, ".dec"},   32'(decrease_duty), e_dec);
    check_eq({ph, ".shadow"}, 32'(duty_shadow),  e_sh);
    check_eq({ph, ".done"},  32'(done),          e_done);
    check_eq({ph, ".ready"}, 32'(cmd_ready),     e_ready);
    check_eq({ph, ".busy"},  32'(busy),          e_busy);
  endtask

  // Builds the shadow trajectory from the command, then predicts every cycle from step index and phase.
  task automatic run_cmd(input bit home, input int tgt, input bit pulse);
    int sh[$];
    int target, steps, dir_up, pulse_t, k, r, final_sh, last;
    target = home ? 1 : (tgt < 1 ? 1 : (tgt > 9 ? 9 : tgt));
    sh.push_back(model_shadow);
    if (home) begin
      steps = 8;
      dir_up = 0;
      for (int i = 0; i < 8; i++) begin
        last = sh[$];
        sh.push_back(last > 1 ? last - 1 : 1);
      end
      final_sh = 1;
    end else begin
      dir_up = (target > model_shadow) ? 1 : 0;
      steps = dir_up ? target - model_shadow : model_shadow - target;
      for (int i = 0; i < steps; i++) begin
        last = sh[$];
        sh.push_back(dir_up ? last + 1 : last - 1);
      end
      final_sh = target;
    end
    pulse_t = pulse ? int'($urandom_range(1, steps * P + 1)) : -1;
    cmd_valid  = 1'b1;
    cmd_home   = home;
    cmd_target = tgt[3:0];
    @(posedge clk);
    for (int t = 1; t <= steps * P + 2; t++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      k = (t - 1) / P;
      r = (t - 1) % P;
      if (t == steps * P + 2)
        check_outputs("idle_after", 0, 0, final_sh, 0, 1, 0);
      else if (k == steps)
        check_outputs("final_eval", 0, 0, sh[steps], 1, 0, 1);
      else if (r == 0)
        check_outputs("eval", 0, 0, sh[k], 0, 0, 1);
      else if (r <= HOLD)
        check_outputs("press", dir_up, 1 - dir_up, sh[k], 0, 0, 1);
      else
        check_outputs("release", 0, 0, sh[k + 1], 0, 0, 1);
      if (t == pulse_t) begin
        cmd_valid  = 1'b1;
        cmd_target = 4'($urandom_range(0, 15));
        cmd_home   = 1'($urandom_range(0, 1));
      end
    end
    cmd_valid = 1'b0;
    model_shadow = final_sh;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs("gap", 0, 0, model_shadow, 0, 1, 0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs("reset", 0, 0, 5, 0, 1, 0);
    rst_n = 1'b1;
    model_shadow = 5;
  endtask

  task automatic reset_mid_press();
    int tgt, up;
    tgt = (model_shadow >= 5) ? 1 : 9;
    up  = (tgt > model_shadow) ? 1 : 0;
    cmd_valid  = 1'b1;
    cmd_home   = 1'b0;
    cmd_target = tgt[3:0];
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_outputs("mid_press", up, 1 - up, model_shadow, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1 check_outputs("async_reset", 0, 0, 5, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_shadow = 5;
    @(negedge clk);
    check_outputs("post_reset", 0, 0, 5, 0, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 0, 5, 0, 1, 0);
    rst_n = 1'b1;
    idle_gap(2);

    run_cmd(1'b0, 5, 1'b0);
    run_cmd(1'b0, 7, 1'b0);
    pulse_reset();
    run_cmd(1'b0, 15, 1'b0);
    run_cmd(1'b0, 0, 1'b0);
    pulse_reset();
    run_cmd(1'b1, 0, 1'b0);
    run_cmd(1'b0, 8, 1'b1);

    for (int i = 0; i < 25; i++) begin
      run_cmd(($urandom_range(0, 4) == 0), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      idle_gap(int'($urandom_range(0, 3)));
    end

    reset_mid_press();
    run_cmd(1'b0, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Command-driven controller for the PWM generator's duty-cycle buttons. It accepts a target duty (1..9 tenths) or a home command over a valid/ready handshake. It then steps the generator one 10% increment at a time by driving its `increase_duty`/`decrease_duty` inputs as held button levels, long enough for the generator's slow-enable debounce to register each step. It keeps a shadow copy of the generator's duty and sits between the top-level command source and the PWM generator.

## Interface
Parameters:
- `MIN_DUTY`, 1: lowest duty step; matches the generator's lower clamp.
- `MAX_DUTY`, 9: highest duty step; matches the generator's upper clamp.
- `INIT_DUTY`, 5: shadow duty after reset; matches the generator's power-up duty.
- `HOLD_CYCLES`, 50_000_010: cycles a button level is held high. Must be at least 2 × 25_000_001.
- `RELEASE_CYCLES`, 50_000_010: cycles the button is held low after each press.
- `TIMER_W`, 28: width of the hold/release timer.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: high only in IDLE. A command is accepted when `cmd_valid & cmd_ready`.
- `cmd_home` in 1: when set with an accepted command, run a home sequence and ignore `cmd_target`.
- `cmd_target` in 4: requested duty step.
- `increase_duty` out 1: button level to the generator.
- `decrease_duty` out 1: button level to the generator.
- `duty_shadow` out 4: tracked generator duty.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- State machine: IDLE → EVAL → PRESS → RELEASE → EVAL …
- IDLE:
  - `cmd_ready`=1.
  - On acceptance, latch `target` = clamp(`cmd_target`, MIN_DUTY, MAX_DUTY).
  - On acceptance, latch `home` = `cmd_home`. When `home` is set, also load `press_cnt` = MAX_DUTY−MIN_DUTY.
  - Go to EVAL.
- EVAL (exactly one cycle):
  - Normal command, `duty_shadow`==`target`: pulse `done`, go to IDLE.
  - Normal command, `duty_shadow`<`target`: direction = up, go to PRESS.
  - Normal command, `duty_shadow`>`target`: direction = down, go to PRESS.
  - Home, `press_cnt`==0: set `duty_shadow`=MIN_DUTY, pulse `done`, go to IDLE.
  - Home, `press_cnt`≠0: direction = down, decrement `press_cnt`, go to PRESS.
- PRESS:
  - Drive the selected button high for exactly HOLD_CYCLES cycles.
  - On exit, update `duty_shadow` by ±1. In home mode, saturate the update at MIN_DUTY.
  - Go to RELEASE.
- RELEASE:
  - Both buttons low for exactly RELEASE_CYCLES cycles.
  - Then go to EVAL.
- Home presses `decrease_duty` unconditionally (MAX_DUTY−MIN_DUTY times). This resynchronises the shadow with a generator whose duty is unknown.
- `increase_duty` and `decrease_duty` are never high together. They are registered outputs with no glitches.
- `cmd_valid` while busy is ignored; the command is not queued.
- Width rules:
  - The timer counts down from HOLD_CYCLES−1 or RELEASE_CYCLES−1 and reloads on every state entry.
  - Duty arithmetic is 4-bit unsigned.
  - Clamping makes out-of-range targets (0, 10..15) legal.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready`=1.
  - `increase_duty`=`decrease_duty`=0.
  - `duty_shadow`=INIT_DUTY.
  - `busy`=0, `done`=0.
  - Timer and `press_cnt` = 0.
- Accept at cycle N:
  - EVAL at N+1.
  - Button high during N+2 … N+1+HOLD_CYCLES.
  - `duty_shadow` changes on the first RELEASE cycle.
- One step costs 1+HOLD_CYCLES+RELEASE_CYCLES cycles.
- `done` is asserted in the final EVAL cycle. `cmd_ready` returns the cycle after it.
- A no-op command (target equals shadow): `done` at N+1, ready at N+2.
- Reset asserted mid-operation:
  - Buttons drop asynchronously.
  - Shadow returns to INIT_DUTY.
  - The generator may now disagree with the shadow; a home command is required.

## Structure
- Shared package holds:
  - State enum (IDLE, EVAL, PRESS, RELEASE).
  - Duty width constant (4).
  - MIN/MAX/INIT duty defaults, shared with the PWM generator.
- One sub-module: `seq_timer`, a loadable down-counter of TIMER_W bits with a `zero` flag.
- The FSM, shadow register and command latch stay in the top.

## Test plan
Bench parameters: HOLD_CYCLES=4, RELEASE_CYCLES=3.
1. Reset, then target 7 at cycle 0 → `increase_duty` high cycles 2-5 and 10-13; shadow 6 at cycle 6 and 7 at cycle 14; `done` at cycle 17.
2. Target 5 from reset → no button activity; `done` at cycle 1; `cmd_ready` high at cycle 2.
3. Target 15, then target 0 → clamped. Shadow reaches 9 after 4 `increase_duty` presses, then 1 after 8 `decrease_duty` presses.
4. Home from reset → 8 `decrease_duty` presses, each 8 cycles apart; `duty_shadow`=1; `done` at cycle 65.
5. `cmd_valid` pulsed mid-ramp → ignored; `cmd_ready` stays low; the original target completes unchanged.
6. `rst_n` low during PRESS → button drops immediately; after release, `duty_shadow`=5 and IDLE with `cmd_ready`=1.
